// File: rtl/rcl_scheduler.sv
// ---------------------------------------------------------------------------
// rcl_scheduler
//   Round-robin front end that shares one circle/line intersection engine
//   among NREQ requesters. The winner's six 5-bit coefficients are captured,
//   replayed to the engine as three (L,Q) beats, and the engine's 2-bit
//   answer (or a timeout) is returned tagged with the requester index.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid[NREQ]          request pending per requester
//   req_ready[NREQ]          one-hot accept strobe, combinational, IDLE only
//   req_coef_l[15*NREQ]      per requester {c,b,a}, 5 bits each
//   req_coef_q[15*NREQ]      per requester {k,n,m}, 5 bits each
//   eng_in_valid             engine beat strobe (registered)
//   eng_coef_L, eng_coef_Q   engine coefficients for the current beat
//   eng_out_valid, eng_out   engine result strobe / 0,1,2 intersection count
//   rsp_valid, rsp_ready     response handshake
//   rsp_id                   requester index of the response
//   rsp_result               engine result, 0 on timeout
//   rsp_timeout              engine did not answer within TIMEOUT cycles
//   busy                     high whenever a job is in flight
// ---------------------------------------------------------------------------
module rcl_scheduler #(
   parameter  int NREQ    = 4,
   parameter  int TIMEOUT = 8,
   localparam int IDW     = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [15*NREQ-1:0]   req_coef_l,
   input  logic [15*NREQ-1:0]   req_coef_q,
   output logic                 eng_in_valid,
   output logic [4:0]           eng_coef_L,
   output logic [4:0]           eng_coef_Q,
   input  logic                 eng_out_valid,
   input  logic [1:0]           eng_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [1:0]           rsp_result,
   output logic                 rsp_timeout,
   output logic                 busy
);

   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RESP} state_t;

   state_t         state_q, state_d;
   logic [1:0]     beat_q, beat_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [IDW-1:0] last_grant_q, last_grant_d;
   logic [IDW-1:0] id_q, id_d;
   logic [14:0]    coef_l_q, coef_l_d;
   logic [14:0]    coef_q_q, coef_q_d;
   logic           eng_in_valid_q, eng_in_valid_d;
   logic [4:0]     eng_l_q, eng_l_d;
   logic [4:0]     eng_q_q, eng_q_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic [1:0]     rsp_result_q, rsp_result_d;
   logic           rsp_timeout_q, rsp_timeout_d;
   logic           busy_q, busy_d;

   // Unpack the flat coefficient buses into per-requester words.
   logic [14:0] l_arr [NREQ];
   logic [14:0] q_arr [NREQ];
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign l_arr[i] = req_coef_l[15*i +: 15];
      assign q_arr[i] = req_coef_q[15*i +: 15];
   end

   // Round-robin pick: first valid requester after last_grant, wrapping.
   logic           grant_vld;
   logic [IDW-1:0] grant_id;
   always_comb begin
      logic [IDW-1:0] idx;
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = '0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = IDW'((int'(last_grant_q) + off) % NREQ);
         if (!grant_vld && req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = idx;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      beat_d         = beat_q;
      timer_d        = timer_q;
      last_grant_d   = last_grant_q;
      id_d           = id_q;
      coef_l_d       = coef_l_q;
      coef_q_d       = coef_q_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_id_d       = rsp_id_q;
      rsp_result_d   = rsp_result_q;
      rsp_timeout_d  = rsp_timeout_q;
      busy_d         = busy_q;
      req_ready      = '0;
      // Engine outputs are rebuilt every cycle so they drop to 0 after beat2.
      eng_in_valid_d = 1'b0;
      eng_l_d        = '0;
      eng_q_d        = '0;

      unique case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               req_ready[grant_id] = 1'b1;
               coef_l_d       = l_arr[grant_id];
               coef_q_d       = q_arr[grant_id];
               id_d           = grant_id;
               last_grant_d   = grant_id;
               busy_d         = 1'b1;
               beat_d         = 2'd0;
               state_d        = S_SEND;
               // Beat 0 is registered on the grant edge so it is on the
               // wires during the first SEND cycle.
               eng_in_valid_d = 1'b1;
               eng_l_d        = l_arr[grant_id][4:0];
               eng_q_d        = q_arr[grant_id][4:0];
            end
         end
         S_SEND: begin
            if (beat_q == 2'd2) begin
               timer_d = '0;
               state_d = S_WAIT;
            end else begin
               beat_d         = beat_q + 2'd1;
               eng_in_valid_d = 1'b1;
               eng_l_d        = (beat_q == 2'd0) ? coef_l_q[9:5] : coef_l_q[14:10];
               eng_q_d        = (beat_q == 2'd0) ? coef_q_q[9:5] : coef_q_q[14:10];
            end
         end
         S_WAIT: begin
            // A result arriving on the expiry cycle takes priority.
            if (eng_out_valid) begin
               rsp_result_d  = eng_out;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_id_d      = id_q;
               state_d       = S_RESP;
            end else if (timer_q == TW'(TIMEOUT-1)) begin
               rsp_result_d  = 2'd0;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               rsp_id_d      = id_q;
               state_d       = S_RESP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         beat_q         <= '0;
         timer_q        <= '0;
         last_grant_q   <= IDW'(NREQ-1);
         id_q           <= '0;
         coef_l_q       <= '0;
         coef_q_q       <= '0;
         eng_in_valid_q <= 1'b0;
         eng_l_q        <= '0;
         eng_q_q        <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= '0;
         rsp_result_q   <= '0;
         rsp_timeout_q  <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         beat_q         <= beat_d;
         timer_q        <= timer_d;
         last_grant_q   <= last_grant_d;
         id_q           <= id_d;
         coef_l_q       <= coef_l_d;
         coef_q_q       <= coef_q_d;
         eng_in_valid_q <= eng_in_valid_d;
         eng_l_q        <= eng_l_d;
         eng_q_q        <= eng_q_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_result_q   <= rsp_result_d;
         rsp_timeout_q  <= rsp_timeout_d;
         busy_q         <= busy_d;
      end
   end

   assign eng_in_valid = eng_in_valid_q;
   assign eng_coef_L   = eng_l_q;
   assign eng_coef_Q   = eng_q_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_timeout  = rsp_timeout_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_rcl_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rcl_scheduler
//   Scenario tasks drive requesters and a scripted engine; expected grants,
//   beats, latencies and responses come from a small transaction-level model
//   (round-robin pick over a valid mask, fixed beat/latency schedule).
// ---------------------------------------------------------------------------
module tb_rcl_scheduler;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 8;
   localparam int IDW     = $clog2(NREQ);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [15*NREQ-1:0]  req_coef_l = '0;
   logic [15*NREQ-1:0]  req_coef_q = '0;
   logic                eng_in_valid;
   logic [4:0]          eng_coef_L, eng_coef_Q;
   logic                eng_out_valid = 1'b0;
   logic [1:0]          eng_out = '0;
   logic                rsp_valid;
   logic                rsp_ready = 1'b0;
   logic [IDW-1:0]      rsp_id;
   logic [1:0]          rsp_result;
   logic                rsp_timeout;
   logic                busy;

   rcl_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_coef_l(req_coef_l), .req_coef_q(req_coef_q),
      .eng_in_valid(eng_in_valid), .eng_coef_L(eng_coef_L), .eng_coef_Q(eng_coef_Q),
      .eng_out_valid(eng_out_valid), .eng_out(eng_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   int nvec = 0, nerr = 0, cyc = 0;
   int exp_last  = NREQ-1;
   int grant_cyc = 0;
   logic [14:0] cl [NREQ];
   logic [14:0] cq [NREQ];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_coefs();
      for (int i = 0; i < NREQ; i++) begin
         req_coef_l[15*i +: 15] = cl[i];
         req_coef_q[15*i +: 15] = cq[i];
      end
   endtask

   task automatic rand_coefs();
      for (int i = 0; i < NREQ; i++) begin
         cl[i] = 15'($urandom);
         cq[i] = 15'($urandom);
      end
   endtask

   // Reference arbitration: first requester after the last winner, wrapping.
   function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
      for (int off = 1; off <= NREQ; off++) begin
         int i;
         i = (last + off) % NREQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // One full job from an IDLE cycle to the IDLE cycle after the handshake.
   // dly: WAIT cycle in which the engine answers (<0 or >=TIMEOUT: never).
   task automatic run_job(input logic [NREQ-1:0] vmask, input int dly,
                          input logic [1:0] res, input int bp, input bit stray);
      int g, w_end;
      bit tmo;
      logic [1:0] exp_res;
      logic [NREQ-1:0] exp_rdy;
      logic [14:0] lat_l, lat_q;
      g = rr_pick(exp_last, vmask);
      req_valid = vmask;
      drive_coefs();
      #1;
      exp_rdy = (g < 0) ? '0 : (NREQ'(1) << g);
      if (req_ready !== exp_rdy) begin
         nerr++; $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
      end
      nvec++;
      if (g < 0) return;
      grant_cyc = cyc;
      exp_last  = g;
      lat_l = cl[g];
      lat_q = cq[g];
      tick();
      // Accepted requester withdraws and changes its bus; the latched copy must be used.
      req_valid[g] = 1'b0;
      cl[g] = 15'($urandom);
      cq[g] = 15'($urandom);
      drive_coefs();
      for (int b = 0; b < 3; b++) begin
         if (stray && b == 1) begin
            eng_out_valid = 1'b1;
            eng_out = 2'($urandom);
         end
         if ({eng_in_valid, eng_coef_L, eng_coef_Q, busy, req_ready} !==
             {1'b1, lat_l[5*b +: 5], lat_q[5*b +: 5], 1'b1, {NREQ{1'b0}}}) begin
            nerr++;
            $display("FAIL beat%0d: v=%b L=%0d Q=%0d busy=%b rdy=%b expected v=1 L=%0d Q=%0d busy=1 rdy=0",
                     b, eng_in_valid, eng_coef_L, eng_coef_Q, busy, req_ready, lat_l[5*b +: 5], lat_q[5*b +: 5]);
         end
         nvec++;
         tick();
         eng_out_valid = 1'b0;
      end
      tmo     = !(dly >= 0 && dly < TIMEOUT);
      w_end   = tmo ? TIMEOUT-1 : dly;
      exp_res = tmo ? 2'd0 : res;
      for (int w = 0; w <= w_end; w++) begin
         if (w == dly) begin
            eng_out_valid = 1'b1;
            eng_out = res;
         end
         if ({eng_in_valid, eng_coef_L, eng_coef_Q, rsp_valid, busy, req_ready} !==
             {1'b0, 5'd0, 5'd0, 1'b0, 1'b1, {NREQ{1'b0}}}) begin
            nerr++;
            $display("FAIL wait%0d: v=%b L=%0d Q=%0d rsp_valid=%b busy=%b rdy=%b expected 0,0,0,0,1,0",
                     w, eng_in_valid, eng_coef_L, eng_coef_Q, rsp_valid, busy, req_ready);
         end
         nvec++;
         tick();
         eng_out_valid = 1'b0;
      end
      for (int k = 0; k <= bp; k++) begin
         rsp_ready = (k == bp);
         if (k < bp) begin
            // Engine chatter while holding the response must be ignored.
            eng_out_valid = 1'b1;
            eng_out = ~exp_res;
         end
         if ({rsp_valid, rsp_id, rsp_result, rsp_timeout, busy, req_ready} !==
             {1'b1, g[IDW-1:0], exp_res, tmo, 1'b1, {NREQ{1'b0}}}) begin
            nerr++;
            $display("FAIL resp%0d: valid=%b id=%0d res=%0d tmo=%b busy=%b rdy=%b expected 1 id=%0d res=%0d tmo=%b busy=1 rdy=0",
                     k, rsp_valid, rsp_id, rsp_result, rsp_timeout, busy, req_ready, g, exp_res, tmo);
         end
         nvec++;
         tick();
         eng_out_valid = 1'b0;
      end
      rsp_ready = 1'b0;
      if ({rsp_valid, busy} !== 2'b00) begin
         nerr++; $display("FAIL idle: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
      end
      nvec++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '0;
      tick();
      tick();
      if ({eng_in_valid, eng_coef_L, eng_coef_Q, rsp_valid, rsp_id, rsp_result, rsp_timeout, busy, req_ready} !== '0) begin
         nerr++;
         $display("FAIL reset: v=%b L=%0d Q=%0d rv=%b id=%0d res=%0d tmo=%b busy=%b rdy=%b expected all 0",
                  eng_in_valid, eng_coef_L, eng_coef_Q, rsp_valid, rsp_id, rsp_result, rsp_timeout, busy, req_ready);
      end
      nvec++;
      rst = 1'b0;
      exp_last = NREQ-1;
   endtask

   task automatic test_single();
      rand_coefs();
      cl[1] = {5'd0, 5'd0, 5'd1};
      cq[1] = {5'd4, 5'd0, 5'd0};
      run_job(4'b0010, 0, 2'd2, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [NREQ-1:0] mask;
      int prev;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_last = NREQ-1;
      rsp_ready = 1'b1;
      mask = '1;
      prev = 0;
      rand_coefs();
      for (int j = 0; j < NREQ; j++) begin
         run_job(mask, 0, 2'($urandom_range(0, 2)), 0, 1'b0);
         if (j > 0) begin
            if (grant_cyc - prev !== 6) begin
               nerr++; $display("FAIL spacing: %0d cycles expected 6", grant_cyc - prev);
            end
            nvec++;
         end
         prev = grant_cyc;
         mask[exp_last] = 1'b0;
      end
   endtask

   task automatic test_round_robin();
      rand_coefs();
      run_job(4'b0100, 0, 2'd1, 0, 1'b0);
      run_job(4'b1001, 0, 2'd2, 0, 1'b0);
      run_job(4'b0001, 0, 2'd0, 0, 1'b0);
   endtask

   task automatic test_timeout();
      rand_coefs();
      run_job(4'b1000, -1, 2'd2, 2, 1'b0);
      // Late engine answer in IDLE: nothing may move.
      req_valid = '0;
      eng_out_valid = 1'b1;
      eng_out = 2'd2;
      tick();
      eng_out_valid = 1'b0;
      tick();
      if ({busy, rsp_valid, eng_in_valid} !== 3'b000) begin
         nerr++; $display("FAIL late_eng: busy=%b rsp_valid=%b eng_in_valid=%b expected 000", busy, rsp_valid, eng_in_valid);
      end
      nvec++;
      // Result on the expiry cycle wins over the timeout.
      run_job(4'b0100, TIMEOUT-1, 2'd1, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      rand_coefs();
      run_job(4'b0111, 0, 2'd1, 5, 1'b1);
   endtask

   task automatic test_reset_mid();
      rand_coefs();
      req_valid = '1;
      drive_coefs();
      #1;
      if (req_ready !== (NREQ'(1) << rr_pick(exp_last, '1))) begin
         nerr++; $display("FAIL mid_grant: req_ready=%b", req_ready);
      end
      nvec++;
      tick();
      req_valid = '0;
      tick();
      if ({eng_in_valid, eng_coef_L} !== {1'b1, cl[rr_pick(exp_last, '1)][9:5]}) begin
         nerr++; $display("FAIL mid_beat1: v=%b L=%0d", eng_in_valid, eng_coef_L);
      end
      nvec++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_last = NREQ-1;
      for (int i = 0; i < 4; i++) begin
         if ({eng_in_valid, eng_coef_L, eng_coef_Q, rsp_valid, rsp_timeout, busy, req_ready} !== '0) begin
            nerr++;
            $display("FAIL mid_reset%0d: v=%b L=%0d Q=%0d rv=%b tmo=%b busy=%b rdy=%b expected all 0",
                     i, eng_in_valid, eng_coef_L, eng_coef_Q, rsp_valid, rsp_timeout, busy, req_ready);
         end
         nvec++;
         tick();
      end
      run_job('1, 0, 2'd2, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int j = 0; j < 40; j++) begin
         rand_coefs();
         run_job(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, TIMEOUT+1),
                 2'($urandom_range(0, 2)), $urandom_range(0, 3), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      rsp_ready = 1'b0;
      test_round_robin();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
